// File: rtl/adpll_chan_seq.sv
// adpll_chan_seq: channel-tuning sequencer in front of the ADPLL control block.
// Each accepted channel request resets the PLL, lets it settle, then waits a
// bounded time for channel_lock. Lock loss and timeouts consume retries until
// the retry budget runs out, at which point the sequencer parks in FAIL.
// Optional build macro ADPLL_CHAN_SEQ_LOCK_FILT_EN: channel_lock must be stable
// for LOCK_FILT consecutive cycles before lock is declared or declared lost.
// FCW width comes from `FCWW (adpll_defines.v); 26 bits if not provided.

`ifndef FCWW
`define FCWW 26
`endif

module adpll_chan_seq #(
   parameter int FCWW        = `FCWW,
   parameter int RST_CYC     = 4,
   parameter int SETTLE_CYC  = 16,
   parameter int LOCK_TO_CYC = 2048,
   parameter int MAX_RETRY   = 3,
   parameter int LOCK_FILT   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic [FCWW-1:0] req_fcw,
   input  logic [1:0]      req_mode,
   input  logic            abort,
   output logic            req_rdy,
   output logic            ack,
   input  logic            channel_lock,
   output logic            adpll_rst,
   output logic            adpll_en,
   output logic [1:0]      adpll_mode,
   output logic [FCWW-1:0] adpll_fcw,
   output logic            busy,
   output logic            locked,
   output logic            lock_fail,
   output logic [3:0]      retry_cnt,
   output logic            tx_go
);

   localparam logic [1:0] MODE_PD = 2'd0;
   localparam logic [1:0] MODE_RX = 2'd2;
   localparam logic [1:0] MODE_TX = 2'd3;

   localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int TW = (LOCK_TO_CYC > 1) ? $clog2(LOCK_TO_CYC) : 1;

   localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYC - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TO_CYC - 1);
   localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_PLL,
      S_SETTLE,
      S_WAIT_LOCK,
      S_LOCKED,
      S_FAIL
   } state_e;

   state_e        state_q;
   logic [RW-1:0] rstCnt_q;
   logic [SW-1:0] settleCnt_q;
   logic [TW-1:0] toCnt_q;

   logic stateRdy;
   logic accept;
   logic doAbort;
   logic lockSeen;
   logic lockLost;
   logic attemptEnd;
   logic retryLeft;

   // Parameter sanity: counters need at least one cycle and retry_cnt is 4 bits.
   generate
      if (RST_CYC < 1 || SETTLE_CYC < 1 || LOCK_TO_CYC < 1 ||
          MAX_RETRY < 0 || MAX_RETRY > 15 || LOCK_FILT < 1) begin : gBadParam
         $error("adpll_chan_seq: parameter out of range");
      end
   endgenerate

`ifdef ADPLL_CHAN_SEQ_LOCK_FILT_EN
   localparam int FW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
   localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);

   logic [FW-1:0] filtCnt_q;

   // Filtered lock decisions: the run counter has already seen LOCK_FILT-1 equal samples.
   assign lockSeen = channel_lock && (filtCnt_q == FILT_LAST);
   assign lockLost = !channel_lock && (filtCnt_q == FILT_LAST);
`else
   // Unfiltered lock decisions: a single sample of channel_lock is trusted.
   assign lockSeen = channel_lock;
   assign lockLost = !channel_lock;
`endif

   // Request qualification and end-of-attempt detection, all from registered state.
   always_comb begin
      stateRdy   = (state_q == S_IDLE) || (state_q == S_LOCKED) || (state_q == S_FAIL);
      accept     = req && stateRdy && !abort &&
                   ((req_mode == MODE_RX) || (req_mode == MODE_TX));
      doAbort    = abort ||
                   (req && (req_mode == MODE_PD) &&
                    ((state_q == S_LOCKED) || (state_q == S_FAIL)));
      attemptEnd = ((state_q == S_WAIT_LOCK) && !lockSeen && (toCnt_q == TO_LAST)) ||
                   ((state_q == S_LOCKED) && lockLost);
      retryLeft  = (retry_cnt < RETRY_MAX);
   end

   // Sequencer FSM: abort beats a new request, a new request beats lock loss,
   // and every output is registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         rstCnt_q    <= '0;
         settleCnt_q <= '0;
         toCnt_q     <= '0;
`ifdef ADPLL_CHAN_SEQ_LOCK_FILT_EN
         filtCnt_q   <= '0;
`endif
         req_rdy     <= 1'b1;
         ack         <= 1'b0;
         adpll_rst   <= 1'b0;
         adpll_en    <= 1'b0;
         adpll_mode  <= MODE_PD;
         adpll_fcw   <= '0;
         busy        <= 1'b0;
         locked      <= 1'b0;
         lock_fail   <= 1'b0;
         retry_cnt   <= '0;
         tx_go       <= 1'b0;
      end else begin
         ack <= 1'b0;
         if (doAbort) begin
            state_q     <= S_IDLE;
            rstCnt_q    <= '0;
            settleCnt_q <= '0;
            toCnt_q     <= '0;
`ifdef ADPLL_CHAN_SEQ_LOCK_FILT_EN
            filtCnt_q   <= '0;
`endif
            req_rdy     <= 1'b1;
            adpll_rst   <= 1'b0;
            adpll_en    <= 1'b0;
            adpll_mode  <= MODE_PD;
            busy        <= 1'b0;
            locked      <= 1'b0;
            tx_go       <= 1'b0;
         end else if (accept) begin
            state_q    <= S_RST_PLL;
            rstCnt_q   <= '0;
`ifdef ADPLL_CHAN_SEQ_LOCK_FILT_EN
            filtCnt_q  <= '0;
`endif
            ack        <= 1'b1;
            adpll_fcw  <= req_fcw;
            adpll_mode <= req_mode;
            retry_cnt  <= '0;
            lock_fail  <= 1'b0;
            req_rdy    <= 1'b0;
            adpll_rst  <= 1'b1;
            adpll_en   <= 1'b0;
            busy       <= 1'b1;
            locked     <= 1'b0;
            tx_go      <= 1'b0;
         end else if (attemptEnd) begin
            locked <= 1'b0;
            tx_go  <= 1'b0;
`ifdef ADPLL_CHAN_SEQ_LOCK_FILT_EN
            filtCnt_q <= '0;
`endif
            if (retryLeft) begin
               state_q   <= S_RST_PLL;
               rstCnt_q  <= '0;
               retry_cnt <= retry_cnt + 4'd1;
               req_rdy   <= 1'b0;
               adpll_rst <= 1'b1;
               adpll_en  <= 1'b0;
               busy      <= 1'b1;
            end else begin
               state_q    <= S_FAIL;
               req_rdy    <= 1'b1;
               adpll_rst  <= 1'b0;
               adpll_en   <= 1'b0;
               adpll_mode <= MODE_PD;
               busy       <= 1'b0;
               lock_fail  <= 1'b1;
            end
         end else begin
            case (state_q)
               S_RST_PLL: begin
                  if (rstCnt_q == RST_LAST) begin
                     state_q     <= S_SETTLE;
                     settleCnt_q <= '0;
                     adpll_rst   <= 1'b0;
                     adpll_en    <= 1'b1;
                  end else begin
                     rstCnt_q <= rstCnt_q + 1'b1;
                  end
               end
               S_SETTLE: begin
                  if (settleCnt_q == SETTLE_LAST) begin
                     state_q <= S_WAIT_LOCK;
                     toCnt_q <= '0;
`ifdef ADPLL_CHAN_SEQ_LOCK_FILT_EN
                     filtCnt_q <= '0;
`endif
                  end else begin
                     settleCnt_q <= settleCnt_q + 1'b1;
                  end
               end
               S_WAIT_LOCK: begin
                  toCnt_q <= toCnt_q + 1'b1;
`ifdef ADPLL_CHAN_SEQ_LOCK_FILT_EN
                  filtCnt_q <= channel_lock ? filtCnt_q + 1'b1 : '0;
`endif
                  if (lockSeen) begin
                     state_q <= S_LOCKED;
                     req_rdy <= 1'b1;
                     busy    <= 1'b0;
                     locked  <= 1'b1;
                     tx_go   <= (adpll_mode == MODE_TX);
`ifdef ADPLL_CHAN_SEQ_LOCK_FILT_EN
                     filtCnt_q <= '0;
`endif
                  end
               end
               S_LOCKED: begin
`ifdef ADPLL_CHAN_SEQ_LOCK_FILT_EN
                  filtCnt_q <= channel_lock ? '0 : filtCnt_q + 1'b1;
`endif
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adpll_chan_seq.sv
// tb_adpll_chan_seq: directed bench for the ADPLL channel sequencer.
// Expected values are hand-derived cycle counts: cycle 1 is the cycle right
// after the accepting edge, RST_PLL spans cycles 1-4, SETTLE 5-20, WAIT_LOCK
// starts at cycle 21, and lock becomes visible LAT cycles after it is seen.
`timescale 1ns/1ps

module tb_adpll_chan_seq;

   localparam int FCWW = 26;
`ifdef ADPLL_CHAN_SEQ_LOCK_FILT_EN
   localparam int LAT = 8;
`else
   localparam int LAT = 1;
`endif
   localparam int ATTEMPT = 4 + 16 + 2048;

   localparam logic [1:0] PD   = 2'd0;
   localparam logic [1:0] TEST = 2'd1;
   localparam logic [1:0] RX   = 2'd2;
   localparam logic [1:0] TX   = 2'd3;

   localparam logic [FCWW-1:0] FCW_2480 = 26'd40632320;
   localparam logic [FCWW-1:0] FCW_2310 = 26'd37847040;

   logic            clock;
   logic            resetN;
   logic            req;
   logic [FCWW-1:0] reqFcw;
   logic [1:0]      reqMode;
   logic            abortIn;
   logic            reqRdy;
   logic            ack;
   logic            channelLock;
   logic            adpllRst;
   logic            adpllEn;
   logic [1:0]      adpllMode;
   logic [FCWW-1:0] adpllFcw;
   logic            busy;
   logic            locked;
   logic            lockFail;
   logic [3:0]      retryCnt;
   logic            txGo;

   int testsRun;
   int testsFailed;

   adpll_chan_seq #(
      .FCWW(FCWW)
   ) dut (
      .clk         (clock),
      .rst         (resetN),
      .req         (req),
      .req_fcw     (reqFcw),
      .req_mode    (reqMode),
      .abort       (abortIn),
      .req_rdy     (reqRdy),
      .ack         (ack),
      .channel_lock(channelLock),
      .adpll_rst   (adpllRst),
      .adpll_en    (adpllEn),
      .adpll_mode  (adpllMode),
      .adpll_fcw   (adpllFcw),
      .busy        (busy),
      .locked      (locked),
      .lock_fail   (lockFail),
      .retry_cnt   (retryCnt),
      .tx_go       (txGo)
   );

   // 10 ns reference clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance n rising edges and land 1 ns after the last one.
   task automatic step(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clock);
         #1;
      end
   endtask

   // Drive the request-side inputs in one go.
   task automatic applyStimulus(input logic r, input logic [FCWW-1:0] f,
                                input logic [1:0] m, input logic a);
      req     = r;
      reqFcw  = f;
      reqMode = m;
      abortIn = a;
   endtask

   // Directed scenarios, run back to back.
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      resetN      = 1'b0;
      channelLock = 1'b0;
      applyStimulus(1'b0, '0, PD, 1'b0);

      #12;
      checkOutput("rstReqRdy", reqRdy, 1);
      checkOutput("rstAck", ack, 0);
      checkOutput("rstAdpllRst", adpllRst, 0);
      checkOutput("rstEn", adpllEn, 0);
      checkOutput("rstMode", adpllMode, PD);
      checkOutput("rstFcw", adpllFcw, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstLocked", locked, 0);
      checkOutput("rstLockFail", lockFail, 0);
      checkOutput("rstRetry", retryCnt, 0);
      checkOutput("rstTxGo", txGo, 0);
      resetN = 1'b1;
      step(2);

      // Lock success, RX at 2480 MHz.
      applyStimulus(1'b1, FCW_2480, RX, 1'b0);
      step(1);
      checkOutput("s1AckPulse", ack, 1);
      checkOutput("s1RstHigh", adpllRst, 1);
      checkOutput("s1EnLowInRst", adpllEn, 0);
      checkOutput("s1FcwLatched", adpllFcw, FCW_2480);
      checkOutput("s1ModeLatched", adpllMode, RX);
      checkOutput("s1Busy", busy, 1);
      checkOutput("s1NotRdy", reqRdy, 0);
      applyStimulus(1'b0, '0, PD, 1'b0);
      step(1);
      checkOutput("s1AckOneCycle", ack, 0);
      step(2);
      checkOutput("s1RstCycle4", adpllRst, 1);
      checkOutput("s1EnCycle4", adpllEn, 0);
      step(1);
      checkOutput("s1RstCycle5", adpllRst, 0);
      checkOutput("s1EnCycle5", adpllEn, 1);
      channelLock = 1'b1;
      step(15);
      checkOutput("s1SettleIgnoresLock", locked, 0);
      checkOutput("s1SettleBusy", busy, 1);
      channelLock = 1'b0;
      step(100);
      checkOutput("s1WaitNoLock", locked, 0);
      checkOutput("s1WaitBusy", busy, 1);
      channelLock = 1'b1;
      step(LAT);
      checkOutput("s1Locked", locked, 1);
      checkOutput("s1TxGoRx", txGo, 0);
      checkOutput("s1LockedNotBusy", busy, 0);
      checkOutput("s1LockedRdy", reqRdy, 1);
      checkOutput("s1Retry0", retryCnt, 0);

      // TEST request is ignored, then retune to 2310 MHz.
      applyStimulus(1'b1, FCW_2310, TEST, 1'b0);
      step(1);
      checkOutput("s2TestNoAck", ack, 0);
      checkOutput("s2TestStillLocked", locked, 1);
      checkOutput("s2TestFcwHeld", adpllFcw, FCW_2480);
      applyStimulus(1'b1, FCW_2310, RX, 1'b0);
      step(1);
      checkOutput("s2RetuneAck", ack, 1);
      checkOutput("s2RetuneFcw", adpllFcw, FCW_2310);
      checkOutput("s2RetuneRst", adpllRst, 1);
      checkOutput("s2RetuneUnlocked", locked, 0);
      applyStimulus(1'b0, '0, PD, 1'b0);
      step(4);
      checkOutput("s2RetuneEn", adpllEn, 1);
      checkOutput("s2RetuneRstLow", adpllRst, 0);
      step(15 + LAT);
      checkOutput("s2NotYetLocked", locked, 0);
      step(1);
      checkOutput("s2Relocked", locked, 1);

      // TX lock, then lock loss and relock.
      applyStimulus(1'b1, FCW_2480, TX, 1'b0);
      step(1);
      checkOutput("s3TxAck", ack, 1);
      checkOutput("s3TxMode", adpllMode, TX);
      applyStimulus(1'b0, '0, PD, 1'b0);
      step(20 + LAT);
      checkOutput("s3TxLocked", locked, 1);
      checkOutput("s3TxGo", txGo, 1);
      channelLock = 1'b0;
      step(LAT - 1);
      checkOutput("s3LockHeld", locked, 1);
      step(1);
      checkOutput("s3TxGoDrop", txGo, 0);
      checkOutput("s3LockedDrop", locked, 0);
      checkOutput("s3Retry1", retryCnt, 1);
      checkOutput("s3RstReentered", adpllRst, 1);
      checkOutput("s3BusyAgain", busy, 1);
      channelLock = 1'b1;
      step(20 + LAT);
      checkOutput("s3Relocked", locked, 1);
      checkOutput("s3TxGoAgain", txGo, 1);
      checkOutput("s3RetryKept", retryCnt, 1);

      // Abort together with a request in LOCKED.
      applyStimulus(1'b1, FCW_2310, RX, 1'b1);
      step(1);
      checkOutput("s4AbortNoAck", ack, 0);
      checkOutput("s4AbortEn", adpllEn, 0);
      checkOutput("s4AbortMode", adpllMode, PD);
      checkOutput("s4AbortUnlocked", locked, 0);
      checkOutput("s4AbortTxGo", txGo, 0);
      checkOutput("s4AbortRdy", reqRdy, 1);
      checkOutput("s4AbortFcwKept", adpllFcw, FCW_2480);

      // Abort in the middle of SETTLE.
      applyStimulus(1'b1, FCW_2310, RX, 1'b0);
      step(1);
      applyStimulus(1'b0, '0, PD, 1'b0);
      step(7);
      checkOutput("s4SettleEn", adpllEn, 1);
      checkOutput("s4SettleBusy", busy, 1);
      abortIn = 1'b1;
      step(1);
      abortIn = 1'b0;
      checkOutput("s4MidAbortEn", adpllEn, 0);
      checkOutput("s4MidAbortMode", adpllMode, PD);
      checkOutput("s4MidAbortRst", adpllRst, 0);
      checkOutput("s4MidAbortBusy", busy, 0);

      // PD request while IDLE is ignored.
      applyStimulus(1'b1, '0, PD, 1'b0);
      step(1);
      checkOutput("s4PdIdleNoAck", ack, 0);
      checkOutput("s4PdIdleNotBusy", busy, 0);
      checkOutput("s4PdIdleFcw", adpllFcw, FCW_2310);

      // Timeout on every attempt, retries, then FAIL.
      channelLock = 1'b0;
      applyStimulus(1'b1, FCW_2480, TX, 1'b0);
      step(1);
      applyStimulus(1'b0, '0, PD, 1'b0);
      for (int a = 1; a <= 3; a++) begin
         step(ATTEMPT - 1);
         checkOutput($sformatf("s5LastCycleRetry%0d", a), retryCnt, a - 1);
         step(1);
         checkOutput($sformatf("s5Retry%0d", a), retryCnt, a);
         checkOutput($sformatf("s5RetryRst%0d", a), adpllRst, 1);
      end
      step(ATTEMPT - 1);
      checkOutput("s5NoFailYet", lockFail, 0);
      checkOutput("s5LastAttemptEn", adpllEn, 1);
      step(1);
      checkOutput("s5LockFail", lockFail, 1);
      checkOutput("s5FailMode", adpllMode, PD);
      checkOutput("s5FailEn", adpllEn, 0);
      checkOutput("s5FailBusy", busy, 0);
      checkOutput("s5FailRetry", retryCnt, 3);
      checkOutput("s5FailRdy", reqRdy, 1);
      checkOutput("s5FailFcwHeld", adpllFcw, FCW_2480);

      // PD request in FAIL acts as abort and keeps lock_fail.
      applyStimulus(1'b1, '0, PD, 1'b0);
      step(1);
      applyStimulus(1'b0, '0, PD, 1'b0);
      checkOutput("s6PdFailNoAck", ack, 0);
      checkOutput("s6PdFailSticky", lockFail, 1);
      checkOutput("s6PdFailEn", adpllEn, 0);

`ifdef ADPLL_CHAN_SEQ_LOCK_FILT_EN
      // Filtered lock: 7 ones, a zero, then 8 ones.
      applyStimulus(1'b1, FCW_2310, RX, 1'b0);
      step(1);
      applyStimulus(1'b0, '0, PD, 1'b0);
      checkOutput("f1FailCleared", lockFail, 0);
      step(20);
      channelLock = 1'b1;
      step(7);
      checkOutput("f1SevenOnes", locked, 0);
      channelLock = 1'b0;
      step(1);
      checkOutput("f1ZeroRestart", locked, 0);
      channelLock = 1'b1;
      step(7);
      checkOutput("f1SevenAgain", locked, 0);
      step(1);
      checkOutput("f1EightOnes", locked, 1);
      channelLock = 1'b0;
`endif

      // New request clears lock_fail; then async reset mid WAIT_LOCK.
      applyStimulus(1'b1, FCW_2310, TX, 1'b0);
      step(1);
      applyStimulus(1'b0, '0, PD, 1'b0);
      checkOutput("s7Ack", ack, 1);
      checkOutput("s7FailCleared", lockFail, 0);
      checkOutput("s7RetryCleared", retryCnt, 0);
      step(30);
      checkOutput("s7WaitBusy", busy, 1);
      checkOutput("s7WaitEn", adpllEn, 1);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("s7AsyncEn", adpllEn, 0);
      checkOutput("s7AsyncMode", adpllMode, PD);
      checkOutput("s7AsyncFcw", adpllFcw, 0);
      checkOutput("s7AsyncBusy", busy, 0);
      checkOutput("s7AsyncRst", adpllRst, 0);
      checkOutput("s7AsyncRdy", reqRdy, 1);
      checkOutput("s7AsyncLocked", locked, 0);
      checkOutput("s7AsyncTxGo", txGo, 0);
      step(2);
      resetN = 1'b1;
      step(2);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/adpll_chan_seq.md
Name: adpll_chan_seq

Overview:
- Channel-tuning sequencer that drives the ADPLL control block's `en`, `adpll_mode`, `FCW` and soft-reset inputs.
- Flow per channel request: reset PLL → settle → wait for `channel_lock` (bounded) → hold lock; relocks on lock loss, retries on timeout, declares failure after a retry limit.
- Sits between the radio MAC register interface and the ADPLL control block on the 32 MHz reference clock.
- In TX it produces the gate that allows `data_mod` toggling only while locked.

Parameters:
- FCWW, `` `FCWW `` (from adpll_defines.v), FCW width (MHz × 16384 word).
- RST_CYC, 4, cycles `adpll_rst` is held high per (re)lock attempt; min 1.
- SETTLE_CYC, 16, cycles after enable before lock detection starts; min 1.
- LOCK_TO_CYC, 2048, WAIT_LOCK timeout in cycles (64 µs at 32 MHz).
- MAX_RETRY, 3, relock/timeout attempts allowed before FAIL; 0..15.
- LOCK_FILT, 8, consecutive lock cycles required (optional feature only).

Ports:
- clk  in  1  32 MHz reference clock.
- rst  in  1  asynchronous reset, active low.
- req  in  1  channel request, sampled when `req_rdy`=1.
- req_fcw  in  FCWW  requested channel word.
- req_mode  in  2  PD=0, TEST=1, RX=2, TX=3.
- abort  in  1  immediate power-down; priority over `req`.
- req_rdy  out  1  high in IDLE, LOCKED, FAIL.
- ack  out  1  one-cycle pulse on accepted request.
- channel_lock  in  1  lock flag from the ADPLL control block.
- adpll_rst  out  1  soft reset to the ADPLL, active high.
- adpll_en  out  1  ADPLL enable.
- adpll_mode  out  2  mode to the ADPLL.
- adpll_fcw  out  FCWW  channel word to the ADPLL.
- busy  out  1  high in RST_PLL, SETTLE, WAIT_LOCK.
- locked  out  1  high in LOCKED.
- lock_fail  out  1  sticky failure flag; cleared on next accepted request.
- retry_cnt  out  4  attempts consumed for the current request.
- tx_go  out  1  `locked` AND latched mode == TX.

Behaviour:
- Reset (`rst`=0, async) values:
  - state = IDLE
  - `adpll_rst`=0, `adpll_en`=0, `adpll_mode`=PD, `adpll_fcw`=0
  - `ack`=0, `busy`=0, `locked`=0, `lock_fail`=0, `retry_cnt`=0, `tx_go`=0
  - all counters cleared
  - Reset mid-sequence returns to these values immediately.
- All outputs are registered.
- States: IDLE, RST_PLL, SETTLE, WAIT_LOCK, LOCKED, FAIL.
- Request acceptance:
  - Accepted when `req`=1, `req_rdy`=1, `abort`=0, and `req_mode` is RX or TX.
  - On accept: `ack` pulses the next cycle; `req_fcw` and `req_mode` are latched into `adpll_fcw`/`adpll_mode` the same edge; `retry_cnt`←0; `lock_fail`←0; state→RST_PLL.
  - A request with `req_mode`=TEST is ignored: no `ack`, no state change.
  - A request with `req_mode`=PD in LOCKED or FAIL is treated as `abort`; in IDLE it is ignored.
- IDLE: `adpll_en`=0, `adpll_mode`=PD.
- RST_PLL:
  - `adpll_rst`=1, `adpll_en`=0 for exactly RST_CYC cycles, then →SETTLE.
- SETTLE:
  - `adpll_rst`=0, `adpll_en`=1 for SETTLE_CYC cycles, then →WAIT_LOCK.
  - `channel_lock` is ignored here.
- WAIT_LOCK (timeout counter starts at 0 on entry):
  - `channel_lock`=1 sampled →LOCKED.
  - Counter reaching LOCK_TO_CYC−1 with no lock:
    - if `retry_cnt` < MAX_RETRY: `retry_cnt`+1, →RST_PLL.
    - else: →FAIL.
  - Lock and timeout on the same cycle: lock wins.
- LOCKED:
  - `locked`=1; `tx_go`=1 if latched mode is TX.
  - New accepted request retunes (→RST_PLL with new word).
  - `channel_lock` falling to 0: `locked`/`tx_go` drop the next cycle, and the same timeout/retry rule as WAIT_LOCK applies: →RST_PLL if retries remain, else →FAIL.
- FAIL:
  - `lock_fail`=1, `adpll_en`=0, `adpll_mode`=PD; `adpll_fcw` holds its value.
  - Waits for a new request or `abort`.
- `abort`=1 in any state: →IDLE on the next edge with `adpll_en`=0, `adpll_mode`=PD, `adpll_rst`=0; `lock_fail` unchanged.
- `retry_cnt` saturates at MAX_RETRY.
- All counters are sized by $clog2 of their parameter.

Optional Feature:
- Macro ADPLL_CHAN_SEQ_LOCK_FILT_EN.
- Defined:
  - Lock is declared only after `channel_lock`=1 for LOCK_FILT consecutive cycles; any 0 restarts the filter count.
  - In LOCKED, lock is lost only after `channel_lock`=0 for LOCK_FILT consecutive cycles.
  - The timeout counter keeps running during filtering.
- Undefined: single-cycle sampling as described in Behaviour; LOCK_FILT is unused.

Test Plan:
- Lock success: reset, `req` with FCW = 2480×16384 (40632320), RX; `channel_lock` rises 100 cycles after SETTLE → `ack` 1 cycle later, `adpll_rst` high 4 cycles, `adpll_en` high from cycle 5, `locked`=1 one cycle after lock, `tx_go`=0.
- Timeout/retry/fail: TX request, `channel_lock` held 0 → 4 attempts of 4+16+2048 cycles each, `retry_cnt` 0→3, then `lock_fail`=1, `adpll_mode`=PD, `adpll_en`=0.
- Lock loss in TX: lock achieved (`tx_go`=1), drop `channel_lock` → `tx_go`=0 next cycle, `retry_cnt`=1, RST_PLL re-entered; reassert lock → `locked`=1.
- Abort mid-SETTLE and simultaneous `abort`+`req` in LOCKED → IDLE next edge, `ack`=0, `adpll_en`=0, `adpll_mode`=PD.
- Retune from LOCKED to 2310×16384 (37847040) → `adpll_fcw` updates on accept edge, full RST_PLL/SETTLE sequence; TEST-mode request → ignored, no `ack`.
- With ADPLL_CHAN_SEQ_LOCK_FILT_EN: `channel_lock` 1 for 7 cycles, 0, then 1 for 8 → `locked` asserts only after the 8-cycle run; async `rst` low mid-WAIT_LOCK → all outputs at reset values immediately.
